// File: rtl/sat_load_sequencer.sv
// Buffers host clause words, then drives one SAT solver run: solver reset, word stream, result wait.
// Results and the buffer persist after a run, so the same formula can be re-run with another start.
module sat_load_sequencer #(
  parameter int NUM_LIT        = 30,
  parameter int DEPTH          = 128,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [NUM_LIT-1:0]         wr_data,
  output logic                       wr_ready,
  input  logic                       clear,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       result_sat,
  output logic                       result_timeout,
  output logic [NUM_LIT-1:0]         result_model,
  output logic [$clog2(DEPTH):0]     word_count,
  output logic                       s_reset,
  output logic                       s_load,
  output logic [NUM_LIT-1:0]         s_i,
  input  logic                       s_ended,
  input  logic                       s_sat,
  input  logic [NUM_LIT-1:0]         s_model,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SRST   = 2'd1,
    ST_STREAM = 2'd2,
    ST_WAIT   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               wr_ready_q, wr_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sat_q, sat_d;
  logic               timeout_q, timeout_d;
  logic [NUM_LIT-1:0] model_q, model_d;
  logic               s_reset_q, s_reset_d;
  logic               s_load_q, s_load_d;
  logic [NUM_LIT-1:0] s_i_q, s_i_d;
  logic               abort;
  logic               wr_en;

  // Clause storage is not reset: word_count alone defines which entries are valid.
  logic [NUM_LIT-1:0] buf_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) buf_q[count_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    done_d    = 1'b0;
    sat_d     = sat_q;
    timeout_d = timeout_q;
    model_d   = model_q;
    abort     = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else begin
          // wr_ready_q is only ever set while count_q < DEPTH, so the write slot is in range.
          if (wr_valid && wr_ready_q) begin
            wr_en   = 1'b1;
            count_d = count_q + CW'(1);
          end
          if (start) begin
            sat_d     = 1'b0;
            timeout_d = 1'b0;
            model_d   = '0;
            if (count_d != '0) begin
              state_d = ST_SRST;
            end else begin
              done_d = 1'b1;
              sat_d  = 1'b1;
            end
          end
        end
      end
      ST_SRST: begin
        state_d = ST_STREAM;
        idx_d   = '0;
      end
      ST_STREAM: begin
        if ({1'b0, idx_q} == count_q - CW'(1)) begin
          state_d = ST_WAIT;
          tcnt_d  = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      ST_WAIT: begin
        if (s_ended) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          sat_d     = s_sat;
          model_d   = s_model;
          timeout_d = 1'b0;
        end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          done_d    = 1'b1;
          sat_d     = 1'b0;
          model_d   = '0;
          timeout_d = 1'b1;
          abort     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Every output is registered from the upcoming state so it lines up with state_q.
    wr_ready_d = (state_d == ST_IDLE) && (count_d < CW'(DEPTH));
    busy_d     = (state_d != ST_IDLE);
    s_reset_d  = (state_d == ST_SRST) || abort;
    s_load_d   = (state_d == ST_STREAM);
    s_i_d      = s_load_d ? buf_q[idx_d] : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      tcnt_q     <= '0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      timeout_q  <= 1'b0;
      model_q    <= '0;
      s_reset_q  <= 1'b1;
      s_load_q   <= 1'b0;
      s_i_q      <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      tcnt_q     <= tcnt_d;
      wr_ready_q <= wr_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      timeout_q  <= timeout_d;
      model_q    <= model_d;
      s_reset_q  <= s_reset_d;
      s_load_q   <= s_load_d;
      s_i_q      <= s_i_d;
    end
  end

  assign wr_ready       = wr_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign result_sat     = sat_q;
  assign result_timeout = timeout_q;
  assign result_model   = model_q;
  assign word_count     = count_q;
  assign s_reset        = s_reset_q;
  assign s_load         = s_load_q;
  assign s_i            = s_i_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sat_load_sequencer.sv
// Bench for sat_load_sequencer: a buffer model feeds an expected-word queue that is
// drained whenever s_load is seen; each scenario task checks its own results.
module tb_sat_load_sequencer;

  localparam int NL    = 30;
  localparam int DEPTH = 16;
  localparam int TMO   = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [NL-1:0] wr_data;
  logic          wr_ready;
  logic          clear;
  logic          start;
  logic          busy;
  logic          done;
  logic          result_sat;
  logic          result_timeout;
  logic [NL-1:0] result_model;
  logic [CW-1:0] word_count;
  logic          s_reset;
  logic          s_load;
  logic [NL-1:0] s_i;
  logic          s_ended;
  logic          s_sat;
  logic [NL-1:0] s_model;
  logic [1:0]    dbg_state;

  sat_load_sequencer #(.NUM_LIT(NL), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clear(clear), .start(start), .busy(busy), .done(done),
    .result_sat(result_sat), .result_timeout(result_timeout), .result_model(result_model),
    .word_count(word_count), .s_reset(s_reset), .s_load(s_load), .s_i(s_i),
    .s_ended(s_ended), .s_sat(s_sat), .s_model(s_model), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int rst_cnt = 0;
  int done_cnt = 0;

  logic [NL-1:0] exp_q[$];
  logic [NL-1:0] mbuf [DEPTH];
  int            mcount = 0;

  // scoreboard: every s_load cycle must deliver the next expected word
  always @(negedge clock) begin
    logic [NL-1:0] e;
    if (s_load === 1'b1) begin
      load_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: s_i=%h loaded with no word expected", s_i);
      end else begin
        e = exp_q.pop_front();
        if (s_i !== e) begin
          errors++;
          $display("FAIL stream_word: s_i=%h expected %h", s_i, e);
        end
      end
    end
    if (s_reset === 1'b1 && reset === 1'b1) rst_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // driver tasks (all start and end at a falling edge)
  task automatic write_word(input logic [NL-1:0] d);
    checks++;
    if (wr_ready !== (mcount < DEPTH)) begin
      errors++;
      $display("FAIL wr_ready: got %b expected %b (count %0d)", wr_ready, (mcount < DEPTH), mcount);
    end
    if (mcount < DEPTH) begin
      mbuf[mcount] = d;
      mcount++;
    end
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clock);
    wr_valid = 1'b0;
  endtask

  task automatic clear_buf();
    clear = 1'b1;
    @(negedge clock);
    clear  = 1'b0;
    mcount = 0;
  endtask

  // end_after < 0 means the solver never ends and the run must time out
  task automatic run_solver(input int end_after, input logic sat, input logic [NL-1:0] model,
                            input bit poke_start);
    int  loads0, rst0, done0, n;
    bit  got;
    loads0 = load_cnt;
    rst0   = rst_cnt;
    done0  = done_cnt;
    for (int i = 0; i < mcount; i++) exp_q.push_back(mbuf[i]);
    start = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (s_reset !== 1'b1 || busy !== 1'b1 || s_load !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL srst: s_reset=%b busy=%b s_load=%b wr_ready=%b done=%b expected 1 1 0 0 0",
               s_reset, busy, s_load, wr_ready, done);
    end
    repeat (mcount + 1) @(negedge clock);
    checks++;
    if (s_load !== 1'b0 || s_i !== '0 || busy !== 1'b1 || load_cnt - loads0 != mcount) begin
      errors++;
      $display("FAIL stream_len: s_load=%b s_i=%h busy=%b loads=%0d expected 0 0 1 %0d",
               s_load, s_i, busy, load_cnt - loads0, mcount);
    end
    if (end_after >= 0) begin
      for (int w = 1; w < end_after; w++) begin
        if (w == 1 && poke_start) start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      checks++;
      if (busy !== 1'b1 || dbg_state !== 2'd3 || done !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold: busy=%b state=%0d done=%b expected 1 3 0", busy, dbg_state, done);
      end
      s_ended = 1'b1;
      s_sat   = sat;
      s_model = model;
      @(negedge clock);
      s_ended = 1'b0;
      s_sat   = 1'b0;
      s_model = '0;
      checks++;
      if (done !== 1'b1 || result_sat !== sat || result_model !== model || result_timeout !== 1'b0 ||
          busy !== 1'b0 || s_reset !== 1'b0) begin
        errors++;
        $display("FAIL result: done=%b sat=%b model=%h tmo=%b busy=%b s_reset=%b expected 1 %b %h 0 0 0",
                 done, result_sat, result_model, result_timeout, busy, s_reset, sat, model);
      end
    end else begin
      got = 1'b0;
      n   = 0;
      for (int k = 1; k <= 20 && !got; k++) begin
        @(negedge clock);
        n = k;
        if (done === 1'b1) got = 1'b1;
      end
      checks++;
      if (!got || n != TMO || s_reset !== 1'b1 || result_timeout !== 1'b1 || result_sat !== 1'b0 ||
          result_model !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout: done_seen=%b after %0d cycles s_reset=%b tmo=%b sat=%b model=%h busy=%b expected 1 %0d 1 1 0 0 0",
                 got, n, s_reset, result_timeout, result_sat, result_model, busy, TMO);
      end
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || s_reset !== 1'b0 || done_cnt - done0 != 1 ||
        rst_cnt - rst0 != (end_after < 0 ? 2 : 1) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL run_after: done=%b s_reset=%b dones=%0d resets=%0d left=%0d expected 0 0 1 %0d 0",
               done, s_reset, done_cnt - done0, rst_cnt - rst0, exp_q.size(), (end_after < 0 ? 2 : 1));
      exp_q.delete();
    end
  endtask

  // scenarios
  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (s_reset !== 1'b1 || wr_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || word_count !== '0 ||
        s_load !== 1'b0 || s_i !== '0 || result_sat !== 1'b0 || result_timeout !== 1'b0 || result_model !== '0) begin
      errors++;
      $display("FAIL reset_values: s_reset=%b wr_ready=%b busy=%b done=%b count=%0d s_load=%b",
               s_reset, wr_ready, busy, done, word_count, s_load);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (s_reset !== 1'b0 || wr_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: s_reset=%b wr_ready=%b state=%0d expected 0 1 0", s_reset, wr_ready, dbg_state);
    end
  endtask

  task automatic test_basic_run();
    write_word(30'h20000000);
    write_word(30'h04000000);
    write_word(30'h10000000);
    checks++;
    if (word_count !== CW'(3)) begin
      errors++;
      $display("FAIL count3: word_count=%0d expected 3", word_count);
    end
    run_solver(6, 1'b1, 30'h2AAAAAAA, 1'b0);
  endtask

  task automatic test_timeout();
    run_solver(-1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_rerun();
    run_solver(2, 1'b0, NL'($urandom), 1'b0);
    run_solver(3, 1'b1, NL'($urandom), 1'b0);
  endtask

  task automatic test_empty_start();
    int loads0;
    clear_buf();
    loads0 = load_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || result_sat !== 1'b1 || result_timeout !== 1'b0 || result_model !== '0 ||
        busy !== 1'b0 || s_reset !== 1'b0) begin
      errors++;
      $display("FAIL empty_start: done=%b sat=%b tmo=%b model=%h busy=%b s_reset=%b expected 1 1 0 0 0 0",
               done, result_sat, result_timeout, result_model, busy, s_reset);
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || result_sat !== 1'b1 || load_cnt != loads0) begin
      errors++;
      $display("FAIL empty_after: done=%b sat=%b loads=%0d expected 0 1 0", done, result_sat, load_cnt - loads0);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH + 2; i++) write_word(NL'($urandom_range(0, 32'h3FFFFFFF)));
    checks++;
    if (word_count !== CW'(DEPTH) || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: word_count=%0d wr_ready=%b expected %0d 0", word_count, wr_ready, DEPTH);
    end
    run_solver(2, 1'b0, NL'($urandom), 1'b0);
  endtask

  task automatic test_clear_start();
    clear_buf();
    write_word(NL'($urandom));
    write_word(NL'($urandom));
    clear = 1'b1;
    start = 1'b1;
    @(negedge clock);
    clear  = 1'b0;
    start  = 1'b0;
    mcount = 0;
    @(negedge clock);
    checks++;
    if (word_count !== '0 || busy !== 1'b0 || done !== 1'b0 || s_reset !== 1'b0) begin
      errors++;
      $display("FAIL clear_start: count=%0d busy=%b done=%b s_reset=%b expected 0 0 0 0",
               word_count, busy, done, s_reset);
    end
  endtask

  task automatic test_write_start();
    logic [NL-1:0] d;
    write_word(NL'($urandom));
    write_word(NL'($urandom));
    d = NL'($urandom);
    mbuf[mcount] = d;
    mcount++;
    wr_valid = 1'b1;
    wr_data  = d;
    run_solver(3, 1'b1, NL'($urandom), 1'b0);
    checks++;
    if (word_count !== CW'(3)) begin
      errors++;
      $display("FAIL write_start_count: word_count=%0d expected 3", word_count);
    end
  endtask

  task automatic test_start_in_wait();
    run_solver(4, 1'b0, NL'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid_stream();
    clear_buf();
    for (int i = 0; i < 4; i++) write_word(NL'($urandom));
    for (int i = 0; i < mcount; i++) exp_q.push_back(mbuf[i]);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (s_load !== 1'b0 || s_reset !== 1'b1 || busy !== 1'b0 || word_count !== '0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: s_load=%b s_reset=%b busy=%b count=%0d wr_ready=%b expected 0 1 0 0 0",
               s_load, s_reset, busy, word_count, wr_ready);
    end
    exp_q.delete();
    mcount = 0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    write_word(NL'($urandom));
    write_word(NL'($urandom));
    write_word(NL'($urandom));
    run_solver(3, 1'b1, NL'($urandom), 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    clear    = 1'b0;
    start    = 1'b0;
    s_ended  = 1'b0;
    s_sat    = 1'b0;
    s_model  = '0;
    test_reset();
    test_basic_run();
    test_timeout();
    test_rerun();
    test_empty_start();
    test_full();
    test_clear_start();
    test_write_start();
    test_start_in_wait();
    test_reset_mid_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sat_load_sequencer.md
Name: sat_load_sequencer

Overview:
Clause-stream controller in front of the SAT solver core (`top`). A host fills an internal clause-word buffer, one NUM_LIT-bit literal word per write. On start, the block resets the solver, streams the buffered words into the solver load port one per cycle, then waits for the solver to finish. It latches sat/model, or flags a timeout, and returns to idle. The buffer contents are retained, so the same formula can be re-run.

Parameters:
NUM_LIT, 30, literal word width; matches common::number_literal.
DEPTH, 128, buffer capacity in words (power of 2).
TIMEOUT_CYCLES, 65535, maximum cycles spent in WAIT before abort (≥1).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
wr_valid  in  1  host word-write request.
wr_data  in  NUM_LIT  clause word to append.
wr_ready  out  1  write accepted when wr_valid&&wr_ready.
clear  in  1  empty the buffer (IDLE only).
start  in  1  launch solve of buffered words.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a result is valid.
result_sat  out  1  solver sat flag, latched.
result_timeout  out  1  run aborted by timeout, latched.
result_model  out  NUM_LIT  solver model, latched.
word_count  out  $clog2(DEPTH)+1  number of words currently buffered.
s_reset  out  1  active-high reset to the solver.
s_load  out  1  solver load strobe.
s_i  out  NUM_LIT  solver literal word input.
s_ended  in  1  solver finished.
s_sat  in  1  solver sat result.
s_model  in  NUM_LIT  solver model.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; word_count=0; all result outputs 0; done=0; busy=0; wr_ready=0 while in reset; s_load=0; s_i=0.
  - s_reset=1: the solver is held in reset.
  - The first cycle after release: s_reset=0, wr_ready=1.
- All outputs are registered.
- FSM: IDLE -> SRST -> STREAM -> WAIT -> IDLE.
- IDLE:
  - wr_ready = (word_count<DEPTH). An accepted write stores wr_data at index word_count; word_count+1.
  - clear=1: word_count<=0 next cycle. clear beats both write and start in the same cycle.
  - start=1 with word_count>0: go to SRST and clear done/results. A write accepted in the same cycle as start is included in the stream.
  - start=1 with word_count=0: no solver activity. Next cycle done=1, result_sat=1 (empty CNF), result_timeout=0, result_model=0; stay IDLE.
- SRST: exactly one cycle, s_reset=1, s_load=0, wr_ready=0, busy=1.
- STREAM:
  - Exactly N=word_count cycles. s_load=1; in the k-th STREAM cycle (k=0..N-1), s_i=buf[k].
  - s_ended is ignored in this state.
- WAIT:
  - Entered after the last word: s_load=0, s_i=0. The timeout counter starts at 0 and increments each WAIT cycle.
  - s_ended=1: latch result_sat=s_sat and result_model=s_model; result_timeout=0. Next cycle is IDLE with done=1.
  - Counter reaching TIMEOUT_CYCLES-1 without s_ended: result_timeout=1, result_sat=0, result_model=0. Next cycle: done=1, s_reset=1 for that one cycle, IDLE.
  - s_ended and timeout in the same cycle: s_ended wins.
- busy=1 in SRST, STREAM and WAIT. While busy: wr_ready=0, and start and clear are ignored.
- Results hold until the next accepted start.
- The buffer is never modified by a run; start again re-streams identical words.
- Write attempts when full (word_count=DEPTH) are refused with wr_ready=0; the word is dropped and never overwrites.
- Reset mid-run: immediate return to the reset values above. Buffer contents are undefined but word_count=0.

Test Plan:
- Fill 3 words (0x20000000, 0x04000000, 0x10000000), start.
  - s_reset high 1 cycle.
  - s_load high exactly 3 cycles with s_i in write order.
  - Model s_ended=1, s_sat=1, s_model=0x2AAAAAAA after 5 WAIT cycles -> done pulse 1 cycle, result_sat=1, result_model=0x2AAAAAAA, busy=0.
- TIMEOUT_CYCLES=8, s_ended held 0 -> done after 8 WAIT cycles, result_timeout=1, result_sat=0, s_reset pulse 1 cycle.
- start with empty buffer -> done next cycle, result_sat=1, s_load never asserted.
- Write DEPTH+2 words -> word_count=DEPTH, wr_ready=0 after the DEPTH-th accept. Start -> s_load high DEPTH cycles.
- Same-cycle cases:
  - clear+start -> word_count=0, no run.
  - write+start with 2 buffered -> 3 words streamed.
  - start pulsed during WAIT -> ignored, a single done.
- Assert reset low mid-STREAM -> s_load=0, s_reset=1, busy=0, word_count=0 asynchronously. Refill and re-run -> correct result.
